// File: rtl/alu_wb_16bits.sv
// ALU with register-file writeback for an 8x16 register file.
// Single-cycle ops write back next cycle; shifts iterate one bit per cycle.
module alu_wb_16bits (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  op,
  input  logic [2:0]  rd_addr,
  input  logic [15:0] rs_data,
  input  logic [15:0] rt_data,
  output logic [15:0] wr_data,
  output logic [2:0]  wr_addr,
  output logic        en,
  output logic        zero,
  output logic        ovf
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    WB    = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [3:0]  cnt;
  logic [15:0] work;
  logic [15:0] work_nx;
  logic        shl_q;
  logic [2:0]  rd_q;
  logic [15:0] res;
  logic        res_ovf;
  logic [3:0]  amt;
  logic        is_shift;
  logic        multi;
  logic        accept;

  assign amt      = rt_data[3:0];
  assign is_shift = op[2] & op[1];
  assign multi    = is_shift && (amt != 4'd0);
  assign accept   = in_valid && in_ready;
  assign work_nx  = shl_q ? (work << 1) : (work >> 1);

  // Combinational result and signed-overflow for the current request
  always_comb begin
    res     = 16'h0000;
    res_ovf = 1'b0;
    unique case (op)
      3'd0: begin
        res     = rs_data + rt_data;
        res_ovf = (rs_data[15] == rt_data[15])
                  && (res[15] != rs_data[15]);
      end
      3'd1: begin
        res     = rs_data - rt_data;
        res_ovf = (rs_data[15] != rt_data[15])
                  && (res[15] != rs_data[15]);
      end
      3'd2: res = rs_data & rt_data;
      3'd3: res = rs_data | rt_data;
      3'd4: res = rs_data ^ rt_data;
      3'd5: res = {15'd0, $signed(rs_data) < $signed(rt_data)};
      3'd6: res = rs_data << amt;
      3'd7: res = rs_data >> amt;
      default: res = 16'h0000;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Next-state, handshake and write-enable decode
  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    en       = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = multi ? SHIFT : WB;
      end
      SHIFT: begin
        if (cnt == 4'd1) state_nx = WB;
      end
      WB: begin
        en       = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Capture, iterative shift, and writeback/flag registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= 4'd0;
      work    <= 16'h0000;
      shl_q   <= 1'b0;
      rd_q    <= 3'd0;
      wr_data <= 16'h0000;
      wr_addr <= 3'd0;
      zero    <= 1'b0;
      ovf     <= 1'b0;
    end else if (accept) begin
      rd_q  <= rd_addr;
      shl_q <= ~op[0];
      work  <= rs_data;
      cnt   <= multi ? amt : 4'd0;
      if (!multi) begin
        wr_data <= res;
        wr_addr <= rd_addr;
        zero    <= (res == 16'h0000);
        ovf     <= res_ovf;
      end
    end else if (state == SHIFT) begin
      work <= work_nx;
      cnt  <= cnt - 4'd1;
      if (cnt == 4'd1) begin
        wr_data <= work_nx;
        wr_addr <= rd_q;
        zero    <= (work_nx == 16'h0000);
        ovf     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_wb_16bits.sv
// Randomized bench for alu_wb_16bits against an arithmetic reference model.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_alu_wb_16bits;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  op = 3'd0;
  logic [2:0]  rd_addr = 3'd0;
  logic [15:0] rs_data = 16'h0;
  logic [15:0] rt_data = 16'h0;
  logic [15:0] wr_data;
  logic [2:0]  wr_addr;
  logic        en;
  logic        zero;
  logic        ovf;

  int errors = 0;
  int checks = 0;

  alu_wb_16bits dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .rd_addr(rd_addr), .rs_data(rs_data), .rt_data(rt_data),
    .wr_data(wr_data), .wr_addr(wr_addr), .en(en), .zero(zero), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic [2:0] o, input logic [15:0] a,
                                input logic [15:0] b, output logic [15:0] r,
                                output logic v);
    int sa, sb, s, k;
    sa = int'($signed(a));
    sb = int'($signed(b));
    k  = int'(b % 16);
    v  = 1'b0;
    case (o)
      3'd0: begin s = sa + sb; r = 16'(s); v = (s > 32767) || (s < -32768); end
      3'd1: begin s = sa - sb; r = 16'(s); v = (s > 32767) || (s < -32768); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = (sa < sb) ? 16'd1 : 16'd0;
      3'd6: r = 16'((32'(a) * (32'd1 << k)) % 65536);
      default: r = 16'(32'(a) / (32'd1 << k));
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [2:0] o, input logic [2:0] rd,
                        input logic [15:0] a, input logic [15:0] b);
    logic [15:0] er;
    logic        ev;
    int          lat;
    model(o, a, b, er, ev);
    lat = (o >= 3'd6 && b[3:0] != 4'd0) ? int'(b[3:0]) + 1 : 1;
    check("ready_before", in_ready, 1);
    in_valid = 1'b1; op = o; rd_addr = rd; rs_data = a; rt_data = b;
    step();
    for (int n = 1; n <= lat + 1; n++) begin
      check("en", en, (n == lat));
      check("in_ready", in_ready, (n == lat + 1));
      if (n >= lat) begin
        check("wr_data", wr_data, er);
        check("wr_addr", wr_addr, rd);
        check("zero", zero, (er == 16'h0));
        check("ovf", ovf, ev);
      end
      if (n <= lat) begin
        in_valid = 1'($urandom);
        op = 3'($urandom); rd_addr = 3'($urandom);
        rs_data = 16'($urandom); rt_data = 16'($urandom);
        step();
      end
    end
    in_valid = 1'b0;
  endtask

  initial begin
    #2;
    check("rst_ready", in_ready, 1);
    check("rst_en", en, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_zero", zero, 0);
    check("rst_ovf", ovf, 0);
    step();
    rst = 1'b1;
    step();

    run_op(3'd0, 3'd3, 16'h7FFF, 16'h0001);
    run_op(3'd1, 3'd5, 16'h0032, 16'h0032);
    run_op(3'd6, 3'd7, 16'h0003, 16'h0004);
    run_op(3'd5, 3'd1, 16'hFFFE, 16'h0001);
    run_op(3'd7, 3'd2, 16'h8000, 16'h000F);
    run_op(3'd1, 3'd0, 16'h8000, 16'h0001);
    run_op(3'd6, 3'd4, 16'hABCD, 16'hFFF0);

    // Reset in the middle of an SHR by 10
    in_valid = 1'b1; op = 3'd7; rd_addr = 3'd6;
    rs_data = 16'hF0F0; rt_data = 16'h000A;
    step();
    in_valid = 1'b0;
    step(); step(); step();
    rst = 1'b0;
    #1;
    check("abort_en", en, 0);
    check("abort_wr_data", wr_data, 0);
    check("abort_wr_addr", wr_addr, 0);
    check("abort_zero", zero, 0);
    check("abort_ovf", ovf, 0);
    step(); step();
    rst = 1'b1;
    #1;
    check("abort_ready", in_ready, 1);
    for (int i = 0; i < 12; i++) begin
      step();
      check("abort_no_en", en, 0);
    end
    run_op(3'd0, 3'd1, 16'h1234, 16'h1111);

    for (int i = 0; i < 300; i++) begin
      logic [15:0] a, b;
      a = 16'($urandom);
      b = 16'($urandom);
      if (i % 10 == 0) b = a;
      run_op(3'($urandom), 3'($urandom), a, b);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
